// File: rtl/simd_dma_pkg.sv
// simd_dma_pkg: shared state encoding and default widths for the SIMD DMA loader.
package simd_dma_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 16;
    localparam int LEN_W      = 8;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dma_state_e;

endpackage

// File: rtl/simd_dma_fifo.sv
// simd_dma_fifo: synchronous show-ahead FIFO. The head word is always on
// pop_data while not empty; push and pop in one cycle keep the count unchanged.
module simd_dma_fifo #(
    parameter int WIDTH = simd_dma_pkg::DATA_W,
    parameter int DEPTH = simd_dma_pkg::FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers; reset flushes the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since empty gates their use.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/simd_dma_loader.sv
// simd_dma_loader: fetches cmd_len words from memory starting at cmd_addr,
// one request at a time, buffers them and streams them to the SIMD unit.
// Optional feature macro: SIMD_DMA_CHECKSUM_EN (running sum of words popped).
//
// Handshakes: the output word transfers on a rising edge where
// (valid_data | valid_instruction) && simd_ready; valid and data never change
// until that edge. A command transfers on cmd_valid && cmd_ready. A memory read
// completes on mem_req && mem_ack; mem_req and mem_addr hold until then and an
// ack with no request outstanding is dropped.
module simd_dma_loader #(
    parameter int DATA_W     = simd_dma_pkg::DATA_W,
    parameter int ADDR_W     = simd_dma_pkg::ADDR_W,
    parameter int LEN_W      = simd_dma_pkg::LEN_W,
    parameter int FIFO_DEPTH = simd_dma_pkg::FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_is_instr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              valid_data,
    output logic              valid_instruction,
    output logic [LEN_W-1:0]  data_size,
    output logic [DATA_W-1:0] data,
    input  logic              simd_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic [1:0]        dbg_state
);

    import simd_dma_pkg::*;

    dma_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  req_cnt_q, req_cnt_d;
    logic [LEN_W-1:0]  sent_cnt_q, sent_cnt_d;
    logic              is_instr_q, is_instr_d;
    logic              mem_req_q, mem_req_d;

    logic                          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic [DATA_W-1:0]             fifo_rdata;
    logic                          accept, ack_taken;

    assign accept    = (state_q == IDLE) && cmd_valid;
    assign ack_taken = mem_req_q && mem_ack;
    assign fifo_push = ack_taken;
    assign fifo_pop  = !fifo_empty && simd_ready;

    simd_dma_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (mem_rdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Transfer sequencing: command capture, request issue, ack bookkeeping, completion.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        req_cnt_d  = req_cnt_q;
        sent_cnt_d = sent_cnt_q;
        is_instr_d = is_instr_q;
        mem_req_d  = mem_req_q;

        if (fifo_pop) sent_cnt_d = sent_cnt_q + LEN_W'(1);

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d     = cmd_addr;
                    len_d      = cmd_len;
                    is_instr_d = cmd_is_instr;
                    req_cnt_d  = '0;
                    sent_cnt_d = '0;
                    if (cmd_len == '0) begin
                        state_d = DONE;
                    end else begin
                        // FIFO is empty here, so the first request can go out at once.
                        state_d   = FETCH;
                        mem_req_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (ack_taken) begin
                    mem_req_d = 1'b0;
                    addr_d    = addr_q + ADDR_W'(1);
                    req_cnt_d = req_cnt_q + LEN_W'(1);
                    if (req_cnt_q + LEN_W'(1) == len_q) state_d = DRAIN;
                end else if (!mem_req_q && (req_cnt_q < len_q) && !fifo_full &&
                             ((int'(fifo_count) + int'(mem_req_q)) < FIFO_DEPTH)) begin
                    // Only request when the word is guaranteed a FIFO slot.
                    mem_req_d = 1'b1;
                end
            end
            DRAIN: begin
                if (sent_cnt_d == len_q) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                len_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset abandons any transfer and drops the outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            req_cnt_q  <= '0;
            sent_cnt_q <= '0;
            is_instr_q <= 1'b0;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            req_cnt_q  <= req_cnt_d;
            sent_cnt_q <= sent_cnt_d;
            is_instr_q <= is_instr_d;
            mem_req_q  <= mem_req_d;
        end
    end

`ifdef SIMD_DMA_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    // Running sum of delivered words, restarted by each accepted command.
    always_comb begin
        csum_d = csum_q;
        if (accept)        csum_d = '0;
        else if (fifo_pop) csum_d = csum_q + fifo_rdata;
    end

    // Checksum register; stays at the final value after the transfer ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) csum_q <= '0;
        else       csum_q <= csum_d;
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    assign cmd_ready         = (state_q == IDLE);
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == DONE);
    assign mem_req           = mem_req_q;
    assign mem_addr          = addr_q;
    assign data_size         = len_q;
    assign valid_data        = !fifo_empty && !is_instr_q;
    assign valid_instruction = !fifo_empty && is_instr_q;
    // Stale storage never leaks out: data reads zero while the FIFO is empty.
    assign data              = fifo_empty ? '0 : fifo_rdata;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_simd_dma_loader.sv
// tb_simd_dma_loader: table vectors, hand-written reset sequence and randomized
// transfers for simd_dma_loader, checked against a list-based transfer model.
// Honours SIMD_DMA_CHECKSUM_EN for the expected checksum value.
module tb_simd_dma_loader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int LEN_W  = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              cmd_is_instr = 1'b0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              valid_data;
    logic              valid_instruction;
    logic [LEN_W-1:0]  data_size;
    logic [DATA_W-1:0] data;
    logic              simd_ready = 1'b0;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] checksum;
    logic [1:0]        dbg_state;

    simd_dma_loader dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_addr          (cmd_addr),
        .cmd_len           (cmd_len),
        .cmd_is_instr      (cmd_is_instr),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_ack           (mem_ack),
        .mem_rdata         (mem_rdata),
        .valid_data        (valid_data),
        .valid_instruction (valid_instruction),
        .data_size         (data_size),
        .data              (data),
        .simd_ready        (simd_ready),
        .busy              (busy),
        .done              (done),
        .checksum          (checksum),
        .dbg_state         (dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;

    // Environment controls.
    int          ready_mode = 0;     // 0 always ready, 1 never ready, 2 random
    logic        resp_en = 1'b1;     // memory model answers requests
    logic        force_ack = 1'b0;   // direct ack drive when resp_en is 0
    logic [31:0] force_rdata = '0;
    int          wait_max = 0;
    int          wait_left = 0;
    logic        spur_en = 1'b0;
    logic [31:0] salt = '0;

    // Scoreboard and observed statistics.
    logic [DATA_W:0]   exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [ADDR_W-1:0] addr_log[$];
    logic [LEN_W-1:0]  cur_len = '0;
    int          beats, done_cnt, ack_cnt, both_bad, ds_bad, hold_bad;
    int          last_hs_cyc, done_cyc, acc_cyc;
    logic        req_seen, hold_pending = 1'b0, held_kind;
    logic [31:0] held_data, first_word, last_word;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  len;
        logic        instr;
        int          stall;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        logic [15:0] exp_last_addr;
        int          exp_lat;   // accept-to-done cycles, 0 = not checked
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return 32'(a) + 32'h100 + salt;
    endfunction

    // One cycle: drive inputs at the falling edge, then sample the DUT mid-cycle.
    task automatic tick();
        logic v;
        logic [DATA_W:0] e;
        @(negedge clk);
        case (ready_mode)
            0:       simd_ready = 1'b1;
            1:       simd_ready = 1'b0;
            default: simd_ready = 1'($urandom_range(0, 1));
        endcase
        if (!resp_en) begin
            mem_ack   = force_ack;
            mem_rdata = force_rdata;
        end else if (mem_req) begin
            if (wait_left == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
                wait_left = $urandom_range(0, wait_max);
            end else begin
                mem_ack = 1'b0;
                wait_left--;
            end
        end else begin
            mem_ack   = spur_en && ($urandom_range(0, 3) == 0);
            mem_rdata = 32'hDEAD_0000 | 32'($urandom_range(0, 255));
        end
        #2;
        v = valid_data | valid_instruction;
        if (mem_req) req_seen = 1'b1;
        if (mem_req && mem_ack) begin
            ack_cnt++;
            addr_log.push_back(mem_addr);
        end
        if (valid_data && valid_instruction) both_bad++;
        if (busy ? (data_size != cur_len) : (data_size != '0)) ds_bad++;
        if (hold_pending && (!v || data != held_data || valid_instruction != held_kind)) hold_bad++;
        hold_pending = v && !simd_ready;
        held_data    = data;
        held_kind    = valid_instruction;
        if (v && simd_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL beat_unexpected: got %0h with no word expected (cycle %0d)", data, cyc);
            end else begin
                e = exp_q.pop_front();
                check("beat", 64'({valid_instruction, data}), 64'(e));
            end
            if (beats == 0) first_word = data;
            last_word   = data;
            last_hs_cyc = cyc;
            beats++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
        check({tag, "_ctrl_zero"}, 64'({mem_req, valid_data, valid_instruction, busy, done}), 64'(0));
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        check({tag, "_data_size"}, 64'(data_size), 64'(0));
        check({tag, "_data"}, 64'(data), 64'(0));
        check({tag, "_checksum"}, 64'(checksum), 64'(0));
    endtask

    // Run one command to completion and compare against the transfer model.
    task automatic run_cmd(input logic [15:0] a, input logic [7:0] n, input logic ins, input int stall);
        logic [15:0] ad;
        logic [31:0] w, sum, exp_ck;
        int k, exp_done, lim;
        exp_q.delete();
        exp_addr_q.delete();
        addr_log.delete();
        sum = '0;
        for (int i = 0; i < int'(n); i++) begin
            ad = a + 16'(i);
            w  = mem_word(ad);
            exp_q.push_back({ins, w});
            exp_addr_q.push_back(ad);
            sum += w;
        end
        beats = 0; done_cnt = 0; ack_cnt = 0; both_bad = 0; ds_bad = 0; hold_bad = 0;
        last_hs_cyc = -100; done_cyc = -100; req_seen = 1'b0; wait_left = 0;

        k = 0;
        while (!cmd_ready && k < 100) begin tick(); k++; end
        check("cmd_ready_wait", 64'(cmd_ready), 64'(1));

        if (stall > 0) ready_mode = 1;
        cur_len      = n;
        cmd_addr     = a;
        cmd_len      = n;
        cmd_is_instr = ins;
        cmd_valid    = 1'b1;
        acc_cyc      = cyc;
        tick();
        cmd_valid = 1'b0;
        check("req_at_t1", 64'(mem_req), 64'(n != 0));
        check("busy_after_accept", 64'(busy), 64'(1));

        if (stall > 0) begin
            repeat (stall) tick();
            lim = (int'(n) < DEPTH) ? int'(n) : DEPTH;
            check("stall_acks", 64'(ack_cnt), 64'(lim));
            check("stall_req_low", 64'(mem_req), 64'(0));
            check("stall_no_beats", 64'(beats), 64'(0));
            ready_mode = 0;
        end

        k = 0;
        while (!done && k < 3000) begin tick(); k++; end
        check("done_seen", 64'(done), 64'(1));
        check("ready_low_in_done", 64'(cmd_ready), 64'(0));
        exp_done = (n == 0) ? acc_cyc + 1 : last_hs_cyc + 1;
        check("done_timing", 64'(done_cyc), 64'(exp_done));
        tick();
        check("ready_after_done", 64'(cmd_ready), 64'(1));
        check("done_pulses", 64'(done_cnt), 64'(1));
        check("beats", 64'(beats), 64'(n));
        check("words_left", 64'(exp_q.size()), 64'(0));
        check("req_seen", 64'(req_seen), 64'(n != 0));
        check("both_valid", 64'(both_bad), 64'(0));
        check("data_size_rule", 64'(ds_bad), 64'(0));
        check("hold_stable", 64'(hold_bad), 64'(0));
        check("addr_count", 64'(addr_log.size()), 64'(exp_addr_q.size()));
        for (int i = 0; i < addr_log.size() && i < exp_addr_q.size(); i++)
            check("mem_addr_seq", 64'(addr_log[i]), 64'(exp_addr_q[i]));
`ifdef SIMD_DMA_CHECKSUM_EN
        exp_ck = sum;
`else
        exp_ck = '0;
`endif
        check("checksum", 64'(checksum), 64'(exp_ck));
    endtask

    initial begin
        vecs[0] = '{16'h0010, 8'd4, 1'b0, 0,  32'h0000_0110, 32'h0000_0113, 16'h0013, 9};
        vecs[1] = '{16'h0200, 8'd3, 1'b1, 0,  32'h0000_0300, 32'h0000_0302, 16'h0202, 7};
        vecs[2] = '{16'h0040, 8'd8, 1'b0, 20, 32'h0000_0140, 32'h0000_0147, 16'h0047, 0};
        vecs[3] = '{16'hFFFE, 8'd3, 1'b0, 0,  32'h0001_00FE, 32'h0000_0100, 16'h0000, 7};
        vecs[4] = '{16'h1234, 8'd0, 1'b0, 0,  32'h0,          32'h0,          16'h0000, 1};
        vecs[5] = '{16'h0100, 8'd1, 1'b1, 0,  32'h0000_0200, 32'h0000_0200, 16'h0100, 3};

        // Power-on reset.
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("por");
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Directed table.
        for (int t = 0; t < 6; t++) begin
            ready_mode = 0; wait_max = 0; spur_en = 1'b0; salt = '0; resp_en = 1'b1;
            run_cmd(vecs[t].addr, vecs[t].len, vecs[t].instr, vecs[t].stall);
            if (vecs[t].len != 0) begin
                check("vec_first", 64'(first_word), 64'(vecs[t].exp_first));
                check("vec_last", 64'(last_word), 64'(vecs[t].exp_last));
                if (addr_log.size() > 0)
                    check("vec_last_addr", 64'(addr_log[addr_log.size()-1]), 64'(vecs[t].exp_last_addr));
            end
            if (vecs[t].exp_lat != 0)
                check("vec_latency", 64'(done_cyc - acc_cyc), 64'(vecs[t].exp_lat));
        end

        // Reset while a request is outstanding, then a late ack.
        resp_en = 1'b0; force_ack = 1'b0; ready_mode = 0;
        cur_len = 8'd6; cmd_addr = 16'h0050; cmd_len = 8'd6; cmd_is_instr = 1'b0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("rst_req_up", 64'(mem_req), 64'(1));
        repeat (3) tick();
        check("rst_req_held", 64'(mem_req), 64'(1));
        check("rst_addr_stable", 64'(mem_addr), 64'(16'h0050));
        reset = 1'b1;
        #1;
        check_reset_outputs("mid");
        tick();
        reset = 1'b0;
        tick();
        force_ack = 1'b1; force_rdata = 32'hBAD0_0001;
        tick();
        force_ack = 1'b0;
        repeat (4) begin
            tick();
            check("late_ack_no_valid", 64'(valid_data | valid_instruction), 64'(0));
        end
        check("late_ack_idle", 64'(cmd_ready), 64'(1));
        resp_en = 1'b1; salt = 32'hFFFF_FF00;
        run_cmd(16'h0001, 8'd2, 1'b0, 0);
        check("rst_recover_last", 64'(last_word), 64'(2));

        // Randomized transfers: random waits, backpressure and stray acks.
        for (int r = 0; r < 15; r++) begin
            ready_mode = 2;
            wait_max   = $urandom_range(0, 2);
            spur_en    = 1'b1;
            salt       = $urandom;
            run_cmd(16'($urandom), 8'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
